bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.
//  Sits directly upstream of the 7-segment scan driver: takes the binary adder sum.
//  Presents DIGITS packed BCD nibbles, so the scan driver indexes digits instead of using / and %.
//  valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//  BIN_W   7   width of binary input (6b+6b sum = 7b, max 126)
//  DIGITS  4   number of BCD digits produced (digit 0 = units)
// PORTS
//  clk          in   1           system clock, all state on posedge
//  rst_n        in   1           async active-low reset
//  in_valid     in   1           in_bin is valid
//  in_ready     out  1           converter idle, can accept
//  in_bin       in   BIN_W       unsigned binary value
//  out_valid    out  1           out_bcd/out_overflow valid, held until out_ready
//  out_ready    in   1           downstream accepts result
//  out_bcd      out  4*DIGITS    packed BCD, [3:0]=units, [7:4]=tens, ...
//  out_overflow out  1           value >= 10**DIGITS; out_bcd holds low DIGITS digits
//  out_blank    out  DIGITS      leading-zero mask, only with BCD_BLANK_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_overflow=0, out_blank=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  in_ready=1. in_valid&&in_ready at edge k: load in_bin, clear BCD, bit counter=BIN_W, go SHIFT.
//   SHIFT: in_ready=0. Each edge: every nibble >=5 gets +3, then {bcd,bin} shifts left 1.
//          A 1 shifted out of the top nibble sets the sticky overflow flag. Counter decrements.
//          Counter reaches 0 -> DONE.
//   DONE:  out_valid=1; out_bcd/out_overflow/out_blank stable. On out_valid&&out_ready, go IDLE.
//  Latency: out_valid rises exactly BIN_W cycles after the accepting edge (7 with defaults).
//  Throughput: one result per BIN_W+2 cycles with out_ready tied high.
//  in_valid during SHIFT/DONE is ignored (in_ready=0); the producer holds data.
//  Output registers keep the last result after the handshake; out_valid drops the cycle after.
//  BIN_W=1 is legal (1-cycle SHIFT). The add-3 test uses >=5 (threshold constant, see STRUCTURE).
//  Reset mid-conversion aborts: all registers return to reset values, no partial result emitted.
// CONFIGURATION
//  BCD_BLANK_EN defined: out_blank[i]=1 if digit i and all higher digits are 0.
//   out_blank[0] is always 0; out_blank is registered with out_bcd.
//  BCD_BLANK_EN undefined: out_blank port absent; no blanking logic.
// STRUCTURE
//  Package bcd_pkg: state typedef (IDLE/SHIFT/DONE), NIBBLE_W=4, ADD3_THRESH=4'd5.
//  Sub-module bcd_add3: combinational nibble correction (in>=5 ? in+3 : in).
//   Instantiated DIGITS times via generate.
//  Top holds FSM, bit counter ($clog2(BIN_W+1)), shift register (4*DIGITS+BIN_W), flags.
// TESTING
//  in_bin=126, out_ready=1 -> out_valid 7 cycles after accept; out_bcd=16'h0126, ovf=0.
//  in_bin=0 -> out_bcd=16'h0000; with BCD_BLANK_EN out_blank=4'b1110.
//  in_bin=9, out_ready=0 for 20 cycles -> out_valid/out_bcd=16'h0009 held; in_ready=0 throughout.
//   out_ready=1 -> IDLE next cycle.
//  BIN_W=14, DIGITS=4, in_bin=12345 -> out_bcd=16'h2345, out_overflow=1.
//   Next in_bin=9999 -> 16'h9999, ovf=0.
//  rst_n low 3 cycles into SHIFT for in_bin=100 -> outputs at reset values, no out_valid.
//   Next in_bin=42 converts to 16'h0042.
//  Back-to-back: in_valid held with 63, then 1 -> second accepted only after first handshake.
//   Results 16'h0063, 16'h0001 in order.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the sequential binary-to-BCD converter.
//   - state_t     : converter FSM states (IDLE / SHIFT / DONE)
//   - NIBBLE_W    : bits per BCD digit
//   - ADD3_THRESH : a digit at or above this value gets +3 before each shift
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          NIBBLE_W    = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

endpackage : bcd_pkg

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
//   Handshake bundle for bin2bcd_seq.
//   Input side : in_valid (prod->conv), in_ready (conv->prod), in_bin
//   Output side: out_valid, out_bcd, out_overflow, out_blank (conv->cons),
//                out_ready (cons->conv)
//   Modports   : master = producer/consumer side, slave = converter side.
//   Optional   : out_blank exists only when BCD_BLANK_EN is defined.
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 4
);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_overflow;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     out_blank;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_overflow, out_blank
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_overflow, out_blank
    );
`else
    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_overflow
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_overflow
    );
`endif

endinterface : bin2bcd_seq_if

// File: rtl/bin2bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble digit correction: o_nib = i_nib + 3 when
//   i_nib >= ADD3_THRESH, otherwise i_nib unchanged.
//   Ports:
//     i_nib  in   NIBBLE_W   BCD digit before the shift
//     o_nib  out  NIBBLE_W   corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nib,
    output logic [NIBBLE_W-1:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= ADD3_THRESH) begin
            o_nib = i_nib + NIBBLE_W'(3);
        end
    end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
//   A value is accepted in IDLE, shifted for BIN_W cycles, then presented in
//   DONE until the consumer takes it. One conversion in flight at a time.
//   Parameters:
//     BIN_W   width of the binary input
//     DIGITS  number of BCD digits produced (digit 0 = units)
//   Ports:
//     clk     in   system clock, all state on posedge
//     rst_n   in   asynchronous active-low reset
//     bus     slave modport of bin2bcd_seq_if (in_* / out_* handshake)
//   Optional feature macro: BCD_BLANK_EN (adds registered out_blank, the
//   leading-zero mask; out_blank[0] is always 0).
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    bin2bcd_seq_if.slave bus
);

    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // FSM
    state_t              r_state;
    state_t              w_state_next;
    logic                w_in_ready;
    logic                w_out_valid;

    // Datapath: r_sr = {bcd digits, remaining binary bits}
    logic [SR_W-1:0]     r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [BCD_W-1:0]    r_out_bcd;
    logic                r_out_ovf;

    logic [BCD_W-1:0]    w_bcd_adj;
    logic [SR_W-1:0]     w_sr_next;
    logic [BCD_W-1:0]    w_bcd_final;
    logic                w_ovf_bit;
    logic                w_last;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]   r_out_blank;
    logic [DIGITS-1:0]   w_blank;
    logic                w_zero_run;
`endif

    // -----------------------------------------------------------------------
    // Digit correction, one add-3 cell per BCD digit
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_sr[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
            .o_nib (w_bcd_adj[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // The top corrected bit is what falls off the BCD field on this shift;
    // a 1 there means the value no longer fits in DIGITS digits.
    assign w_ovf_bit   = w_bcd_adj[BCD_W-1];
    assign w_sr_next   = {w_bcd_adj[BCD_W-2:0], r_sr[BIN_W-1:0], 1'b0};
    assign w_bcd_final = w_sr_next[SR_W-1:BIN_W];
    assign w_last      = (r_cnt == CNT_W'(1));

`ifdef BCD_BLANK_EN
    // Walk from the most significant digit down; a digit is blank only while
    // every digit above it (and itself) is zero. Units digit never blanks.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (w_bcd_final[i*NIBBLE_W +: NIBBLE_W] == '0);
            w_blank[i] = w_zero_run;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_bcd <= '0;
            r_out_ovf <= 1'b0;
`ifdef BCD_BLANK_EN
            r_out_blank <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone completes the handshake
                    if (bus.in_valid) begin
                        r_sr  <= SR_W'(bus.in_bin);
                        r_cnt <= CNT_W'(BIN_W);
                        r_ovf <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_ovf <= r_ovf | w_ovf_bit;
                    // Results are captured straight from the final shift so
                    // they are ready the same edge the FSM enters DONE, and
                    // remain after the output handshake.
                    if (w_last) begin
                        r_out_bcd <= w_bcd_final;
                        r_out_ovf <= r_ovf | w_ovf_bit;
`ifdef BCD_BLANK_EN
                        r_out_blank <= w_blank;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_bcd      = r_out_bcd;
    assign bus.out_overflow = r_out_ovf;
`ifdef BCD_BLANK_EN
    assign bus.out_blank    = r_out_blank;
`endif

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq. Two instances: BIN_W=7 (sel 0) and
//   BIN_W=14 (sel 1), both DIGITS=4. Expected results come from a decimal
//   model pushed to a scoreboard queue at accept time.
//   Optional macro: BCD_BLANK_EN (also checks out_blank).
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(7),  .DIGITS(4)) bus7  ();
    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus14 ();

    bin2bcd_seq #(.BIN_W(7),  .DIGITS(4)) dut7  (.clk(clk), .rst_n(rst_n), .bus(bus7));
    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (.clk(clk), .rst_n(rst_n), .bus(bus14));

    // ---------------- model and access helpers ----------------
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned r;
        bit          z;
        r = v;
        z = 1'b1;
        e.bcd   = '0;
        e.blank = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.ovf = (r != 0);
        for (int i = 3; i >= 1; i--) begin
            z = z && (e.bcd[i*4 +: 4] == 4'd0);
            e.blank[i] = z;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v, input int unsigned b);
        if (sel == 0) begin
            bus7.in_valid = v;
            bus7.in_bin   = 7'(b);
        end else begin
            bus14.in_valid = v;
            bus14.in_bin   = 14'(b);
        end
    endtask

    task automatic set_rdy(input int sel, input logic r);
        if (sel == 0) bus7.out_ready = r;
        else          bus14.out_ready = r;
    endtask

    function automatic logic g_in_ready(input int sel);
        return (sel == 0) ? bus7.in_ready : bus14.in_ready;
    endfunction

    function automatic logic g_out_valid(input int sel);
        return (sel == 0) ? bus7.out_valid : bus14.out_valid;
    endfunction

    function automatic logic [15:0] g_bcd(input int sel);
        return (sel == 0) ? bus7.out_bcd : bus14.out_bcd;
    endfunction

    function automatic logic g_ovf(input int sel);
        return (sel == 0) ? bus7.out_overflow : bus14.out_overflow;
    endfunction

`ifdef BCD_BLANK_EN
    function automatic logic [3:0] g_blank(input int sel);
        return (sel == 0) ? bus7.out_blank : bus14.out_blank;
    endfunction
`endif

    // Bounded wait for out_valid; reports cycles waited.
    task automatic wait_valid(input int sel, input int max, output int cyc, output bit ok);
        cyc = 0;
        while (!g_out_valid(sel) && cyc < max) begin
            tick();
            cyc++;
        end
        ok = g_out_valid(sel);
    endtask

    // Bounded wait for in_ready, then one accepted transfer with scoreboard push.
    task automatic send(input int sel, input int unsigned v, output bit ok);
        int c;
        c = 0;
        while (!g_in_ready(sel) && c < 50) begin
            tick();
            c++;
        end
        ok = g_in_ready(sel);
        if (ok) begin
            set_in(sel, 1'b1, v);
            sb.push_back(model(v));
            tick();
            set_in(sel, 1'b0, 0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (g_in_ready(s) !== 1'b1 || g_out_valid(s) !== 1'b0 ||
                g_bcd(s) !== 16'h0000 || g_ovf(s) !== 1'b0)
                $display("FAIL reset[%0d]: rdy=%b vld=%b bcd=%h ovf=%b, want 1 0 0000 0",
                         s, g_in_ready(s), g_out_valid(s), g_bcd(s), g_ovf(s));
            else n_pass++;
`ifdef BCD_BLANK_EN
            n_checks++;
            if (g_blank(s) !== 4'b0000)
                $display("FAIL reset_blank[%0d]: got %b want 0000", s, g_blank(s));
            else n_pass++;
`endif
        end
    endtask

    task automatic test_latency;
        int   cyc;
        bit   ok;
        exp_t e;
        set_rdy(0, 1'b1);
        n_checks++;
        if (g_in_ready(0) !== 1'b1) $display("FAIL lat_idle: in_ready=%b want 1", g_in_ready(0));
        else n_pass++;
        set_in(0, 1'b1, 126);
        sb.push_back(model(126));
        tick();                                   // accepting edge
        set_in(0, 1'b0, 0);
        n_checks++;
        if (g_in_ready(0) !== 1'b0) $display("FAIL lat_busy: in_ready=%b want 0", g_in_ready(0));
        else n_pass++;
        wait_valid(0, 30, cyc, ok);
        n_checks++;
        if (!ok || cyc != 7) $display("FAIL lat_cycles: got %0d (valid=%b) want 7", cyc, ok);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (g_bcd(0) !== e.bcd || g_ovf(0) !== e.ovf)
            $display("FAIL lat_126: bcd=%h ovf=%b want %h %b", g_bcd(0), g_ovf(0), e.bcd, e.ovf);
        else n_pass++;
        tick();                                   // handshake edge
        n_checks++;
        if (g_out_valid(0) !== 1'b0 || g_in_ready(0) !== 1'b1)
            $display("FAIL lat_release: vld=%b rdy=%b want 0 1", g_out_valid(0), g_in_ready(0));
        else n_pass++;
        set_rdy(0, 1'b0);
    endtask

    task automatic test_zero;
        int   cyc;
        bit   ok;
        exp_t e;
        send(0, 0, ok);
        wait_valid(0, 30, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || g_bcd(0) !== e.bcd || g_ovf(0) !== e.ovf)
            $display("FAIL zero: vld=%b bcd=%h ovf=%b want 1 %h %b", ok, g_bcd(0), g_ovf(0), e.bcd, e.ovf);
        else n_pass++;
`ifdef BCD_BLANK_EN
        n_checks++;
        if (g_blank(0) !== e.blank)
            $display("FAIL zero_blank: got %b want %b", g_blank(0), e.blank);
        else n_pass++;
`endif
        set_rdy(0, 1'b1);
        tick();
        set_rdy(0, 1'b0);
    endtask

    task automatic test_hold;
        int   cyc;
        bit   ok;
        int   bad;
        exp_t e;
        set_rdy(0, 1'b0);
        send(0, 9, ok);
        wait_valid(0, 30, cyc, ok);
        e = sb.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (g_out_valid(0) !== 1'b1 || g_bcd(0) !== e.bcd ||
                g_ovf(0) !== e.ovf || g_in_ready(0) !== 1'b0)
                bad++;
            tick();
        end
        n_checks++;
        if (!ok || bad != 0) $display("FAIL hold_9: %0d bad cycles (valid=%b) want 0", bad, ok);
        else n_pass++;
        set_rdy(0, 1'b1);
        tick();
        set_rdy(0, 1'b0);
        n_checks++;
        if (g_out_valid(0) !== 1'b0 || g_in_ready(0) !== 1'b1 || g_bcd(0) !== e.bcd)
            $display("FAIL hold_release: vld=%b rdy=%b bcd=%h want 0 1 %h",
                     g_out_valid(0), g_in_ready(0), g_bcd(0), e.bcd);
        else n_pass++;
    endtask

    task automatic test_wide;
        int unsigned vals[4] = '{12345, 9999, 10000, 16383};
        int   cyc;
        bit   ok;
        exp_t e;
        foreach (vals[k]) begin
            send(1, vals[k], ok);
            wait_valid(1, 40, cyc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || cyc != 14 || g_bcd(1) !== e.bcd || g_ovf(1) !== e.ovf)
                $display("FAIL wide_%0d: vld=%b cyc=%0d bcd=%h ovf=%b want 1 14 %h %b",
                         vals[k], ok, cyc, g_bcd(1), g_ovf(1), e.bcd, e.ovf);
            else n_pass++;
            set_rdy(1, 1'b1);
            tick();
            set_rdy(1, 1'b0);
        end
    endtask

    task automatic test_reset_abort;
        int   cyc;
        bit   ok;
        int   bad;
        exp_t e;
        send(0, 100, ok);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (g_in_ready(0) !== 1'b1 || g_out_valid(0) !== 1'b0 ||
            g_bcd(0) !== 16'h0000 || g_ovf(0) !== 1'b0)
            $display("FAIL abort_reset: rdy=%b vld=%b bcd=%h ovf=%b want 1 0 0000 0",
                     g_in_ready(0), g_out_valid(0), g_bcd(0), g_ovf(0));
        else n_pass++;
        sb.delete();
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (g_out_valid(0) !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_valid: %0d cycles with out_valid, want 0", bad);
        else n_pass++;
        send(0, 42, ok);
        wait_valid(0, 30, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || g_bcd(0) !== e.bcd || g_ovf(0) !== e.ovf)
            $display("FAIL abort_42: vld=%b bcd=%h ovf=%b want 1 %h %b", ok, g_bcd(0), g_ovf(0), e.bcd, e.ovf);
        else n_pass++;
        set_rdy(0, 1'b1);
        tick();
        set_rdy(0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int   acc_cyc[2];
        int   hs_cyc[2];
        int   n_acc;
        int   n_res;
        bit   acc;
        bit   hs;
        exp_t e;
        n_acc = 0;
        n_res = 0;
        sb.push_back(model(63));
        sb.push_back(model(1));
        set_rdy(0, 1'b1);
        set_in(0, 1'b1, 63);
        for (int c = 0; c < 60 && n_res < 2; c++) begin
            acc = bus7.in_valid && g_in_ready(0);
            hs  = g_out_valid(0) && bus7.out_ready;
            if (hs) begin
                e = sb.pop_front();
                n_checks++;
                if (g_bcd(0) !== e.bcd || g_ovf(0) !== e.ovf)
                    $display("FAIL b2b_res%0d: bcd=%h ovf=%b want %h %b", n_res, g_bcd(0), g_ovf(0), e.bcd, e.ovf);
                else n_pass++;
                hs_cyc[n_res] = c;
                n_res++;
            end
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            tick();
            if (acc && n_acc == 1) set_in(0, 1'b1, 1);
            if (acc && n_acc == 2) set_in(0, 1'b0, 0);
        end
        set_rdy(0, 1'b0);
        set_in(0, 1'b0, 0);
        n_checks++;
        if (n_res != 2 || n_acc != 2)
            $display("FAIL b2b_count: results=%0d accepts=%0d want 2 2", n_res, n_acc);
        else n_pass++;
        if (n_res == 2 && n_acc == 2) begin
            n_checks++;
            if (acc_cyc[1] <= hs_cyc[0] || acc_cyc[1] - acc_cyc[0] != 9)
                $display("FAIL b2b_order: accept2 at %0d, result1 at %0d, accept1 at %0d; want accept2>result1 and spacing 9",
                         acc_cyc[1], hs_cyc[0], acc_cyc[0]);
            else n_pass++;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b1;
        set_in(0, 1'b0, 0);
        set_in(1, 1'b0, 0);
        set_rdy(0, 1'b0);
        set_rdy(1, 1'b0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_latency();
        test_zero();
        test_hold();
        test_wide();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_bin2bcd_seq
